// File: rtl/siu_niu_mon_pkg.sv
// Shared types, field positions and parity helper for the SIU-to-NIU response packet monitor.
package siu_niu_mon_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAPW = 2'd1,
    PAY  = 2'd2
  } mon_state_e;

  localparam int unsigned RES_TYPE_W = 6;
  localparam int unsigned TAG_LSB    = 64;
  localparam int unsigned TAG_W      = 16;
  localparam int unsigned PAR_SLICE  = 16;

  // Expected parity bit for one 16-bit data slice.
  function automatic logic slice_par(input logic [PAR_SLICE-1:0] d, input logic odd);
    return (^d) ^ odd;
  endfunction

endpackage

// File: rtl/siu_niu_mon_ch.sv
// Single-channel SIU-to-NIU packet monitor: header capture, payload tracking, counters, sticky errors.
// Parity checking is built only when SIU_NIU_MON_PAR_CHK_EN is defined.
module siu_niu_mon_ch
  import siu_niu_mon_pkg::*;
#(
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned PAR_W   = DATA_W / 16,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned GAP     = 1,
  parameter int unsigned PAR_ODD = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                  iol2clk,
  input  logic                  rst_l,
  input  logic                  mon_en,
  input  logic                  err_clr,
  input  logic                  hdr_vld,
  input  logic                  datareq,
  input  logic [DATA_W-1:0]     data,
  input  logic [PAR_W-1:0]      parity,
  output logic                  hdr_evt,
  output logic                  hdr_has_data,
  output logic [RES_TYPE_W-1:0] res_type,
  output logic [TAG_W-1:0]      tag_id,
  output logic                  pay_done,
  output logic                  par_err,
  output logic                  proto_err,
  output logic [CNT_W-1:0]      hdr_cnt,
  output logic [CNT_W-1:0]      pay_cnt
);

  localparam logic [3:0] LAST_BEAT = 4'(BEATS - 1);
  localparam logic [1:0] GAP_LD    = 2'(GAP);

  mon_state_e state;
  logic [3:0] beat_cnt;
  logic [1:0] gap_cnt;
  logic       par_bad_c;
  logic       proto_set_c;
  logic       par_set_c;

`ifdef SIU_NIU_MON_PAR_CHK_EN
  logic [PAR_W-1:0] par_exp_c;

  always_comb begin
    par_exp_c = '0;
    for (int i = 0; i < int'(PAR_W); i++) begin
      par_exp_c[i] = slice_par(data[i*PAR_SLICE +: PAR_SLICE], 1'(PAR_ODD));
    end
  end

  assign par_bad_c = (par_exp_c != parity);
`else
  logic unused_par;

  assign unused_par = ^{parity, data, 1'(PAR_ODD)};
  assign par_bad_c  = 1'b0;
`endif

  // Overlapping headers and stray datareq in IDLE are protocol violations.
  assign proto_set_c = ((state != IDLE) && hdr_vld) || ((state == IDLE) && datareq && !hdr_vld);
  assign par_set_c   = (state == PAY) && par_bad_c;

  always_ff @(posedge iol2clk or negedge rst_l) begin
    if (!rst_l) begin
      state        <= IDLE;
      beat_cnt     <= '0;
      gap_cnt      <= '0;
      hdr_evt      <= 1'b0;
      hdr_has_data <= 1'b0;
      res_type     <= '0;
      tag_id       <= '0;
      pay_done     <= 1'b0;
      par_err      <= 1'b0;
      proto_err    <= 1'b0;
      hdr_cnt      <= '0;
      pay_cnt      <= '0;
    end else begin
      hdr_evt  <= 1'b0;
      pay_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (mon_en && hdr_vld) begin
            hdr_evt      <= 1'b1;
            hdr_has_data <= datareq;
            res_type     <= data[DATA_W-1 -: RES_TYPE_W];
            tag_id       <= data[TAG_LSB +: TAG_W];
            hdr_cnt      <= (&hdr_cnt) ? hdr_cnt : hdr_cnt + CNT_W'(1);
            if (datareq) begin
              beat_cnt <= '0;
              gap_cnt  <= GAP_LD;
              state    <= (GAP == 0) ? PAY : GAPW;
            end
          end
        end
        GAPW: begin
          if (gap_cnt <= 2'd1) state <= PAY;
          else                 gap_cnt <= gap_cnt - 2'd1;
        end
        PAY: begin
          beat_cnt <= beat_cnt + 4'd1;
          if (beat_cnt == LAST_BEAT) begin
            state    <= IDLE;
            pay_done <= 1'b1;
            pay_cnt  <= (&pay_cnt) ? pay_cnt : pay_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
      // A new error in the clear cycle wins over the clear.
      proto_err <= (proto_err & ~err_clr) | proto_set_c;
      par_err   <= (par_err & ~err_clr) | par_set_c;
    end
  end

endmodule

// File: rtl/siu_niu_pkt_mon_mc.sv
// Multi-channel SIU-to-NIU outbound response packet monitor; one siu_niu_mon_ch per channel.
// Optional parity checking enabled by defining SIU_NIU_MON_PAR_CHK_EN.
module siu_niu_pkt_mon_mc
  import siu_niu_mon_pkg::*;
#(
  parameter int unsigned NUM_CH  = 1,
  parameter int unsigned DATA_W  = 128,
  parameter int unsigned PAR_W   = DATA_W / 16,
  parameter int unsigned BEATS   = 4,
  parameter int unsigned GAP     = 1,
  parameter int unsigned PAR_ODD = 0,
  parameter int unsigned CNT_W   = 16
) (
  input  logic                         iol2clk,
  input  logic                         rst_l,
  input  logic                         mon_en,
  input  logic                         err_clr,
  input  logic [NUM_CH-1:0]            sio_niu_hdr_vld,
  input  logic [NUM_CH-1:0]            sio_niu_datareq,
  input  logic [NUM_CH*DATA_W-1:0]     sio_niu_data,
  input  logic [NUM_CH*PAR_W-1:0]      sio_niu_parity,
  output logic [NUM_CH-1:0]            hdr_evt,
  output logic [NUM_CH-1:0]            hdr_has_data,
  output logic [NUM_CH*RES_TYPE_W-1:0] res_type,
  output logic [NUM_CH*TAG_W-1:0]      tag_id,
  output logic [NUM_CH-1:0]            pay_done,
  output logic [NUM_CH-1:0]            par_err,
  output logic [NUM_CH-1:0]            proto_err,
  output logic [NUM_CH*CNT_W-1:0]      hdr_cnt,
  output logic [NUM_CH*CNT_W-1:0]      pay_cnt
);

  for (genvar c = 0; c < int'(NUM_CH); c++) begin : g_ch
    siu_niu_mon_ch #(
      .DATA_W  (DATA_W),
      .PAR_W   (PAR_W),
      .BEATS   (BEATS),
      .GAP     (GAP),
      .PAR_ODD (PAR_ODD),
      .CNT_W   (CNT_W)
    ) u_ch (
      .iol2clk      (iol2clk),
      .rst_l        (rst_l),
      .mon_en       (mon_en),
      .err_clr      (err_clr),
      .hdr_vld      (sio_niu_hdr_vld[c]),
      .datareq      (sio_niu_datareq[c]),
      .data         (sio_niu_data[c*DATA_W +: DATA_W]),
      .parity       (sio_niu_parity[c*PAR_W +: PAR_W]),
      .hdr_evt      (hdr_evt[c]),
      .hdr_has_data (hdr_has_data[c]),
      .res_type     (res_type[c*RES_TYPE_W +: RES_TYPE_W]),
      .tag_id       (tag_id[c*TAG_W +: TAG_W]),
      .pay_done     (pay_done[c]),
      .par_err      (par_err[c]),
      .proto_err    (proto_err[c]),
      .hdr_cnt      (hdr_cnt[c*CNT_W +: CNT_W]),
      .pay_cnt      (pay_cnt[c*CNT_W +: CNT_W])
    );
  end

endmodule

// File: doc/siu_niu_pkt_mon_mc.md
Name: siu_niu_pkt_mon_mc

Overview:
- Synthesizable, parametrised multi-channel monitor for SIU-to-NIU outbound response packets. Sits alongside the SIO outbound ports and snoops them; never drives the interface.
- Per channel it detects header cycles, captures the response type and tag, and tracks payload beats. It also checks payload parity, counts headers and payloads, and flags protocol violations.
- Outputs are registered event pulses, counters and sticky error flags for checkers, coverage and debug CSR export.

Parameters:
- NUM_CH, 1, number of independent SIU-to-NIU channels monitored.
- DATA_W, 128, data bus width per channel; must be a multiple of 16 and at least 128.
- PAR_W, DATA_W/16, parity bits per channel; one bit per 16-bit data slice.
- BEATS, 4, payload beats per data-carrying packet; legal range 1..15.
- GAP, 1, idle cycles between the header and the first payload beat; legal range 0..3.
- PAR_ODD, 0, 0 selects even parity, 1 selects odd parity.
- CNT_W, 16, width of the per-channel counters.

Ports:
- iol2clk  in  1  clock.
- rst_l  in  1  asynchronous active-low reset.
- mon_en  in  1  global enable; when 0, no new headers are accepted.
- err_clr  in  1  single-cycle pulse; clears all sticky errors.
- sio_niu_hdr_vld  in  NUM_CH  header-valid, one bit per channel.
- sio_niu_datareq  in  NUM_CH  payload follows, sampled in the header cycle.
- sio_niu_data  in  NUM_CH*DATA_W  data bus; channel c occupies slice [c*DATA_W +: DATA_W].
- sio_niu_parity  in  NUM_CH*PAR_W  parity bus; channel c occupies slice [c*PAR_W +: PAR_W].
- hdr_evt  out  NUM_CH  one-cycle pulse per accepted header.
- hdr_has_data  out  NUM_CH  captured datareq of the last accepted header.
- res_type  out  NUM_CH*6  captured data[DATA_W-1:DATA_W-6] of the last header.
- tag_id  out  NUM_CH*16  captured data[79:64] of the last header.
- pay_done  out  NUM_CH  one-cycle pulse after the final payload beat.
- par_err  out  NUM_CH  sticky parity error.
- proto_err  out  NUM_CH  sticky protocol error.
- hdr_cnt  out  NUM_CH*CNT_W  accepted-header count, saturating.
- pay_cnt  out  NUM_CH*CNT_W  completed-payload count, saturating.

Behaviour:
- Reset (rst_l=0, asynchronous) forces every output to 0 and every channel FSM to IDLE. Reset asserted mid-packet abandons the packet with no pay_done and no error.
- Channels are fully independent; channel c uses only the slices belonging to c.
- Per-channel FSM states are IDLE, GAPW and PAY.
- IDLE: if mon_en & hdr_vld, the header is accepted.
  - Cycle H+1: hdr_evt pulses; res_type, tag_id and hdr_has_data update; hdr_cnt increments.
  - If datareq=1: next state is GAPW (or PAY when GAP=0), with the gap counter loaded to GAP.
  - If datareq=0: stay in IDLE. This is a write-ack only packet and produces no pay_done.
- GAPW: gap counter decrements each cycle; enter PAY when it reaches 1. The first beat therefore lands at cycle H+1+GAP.
- PAY: each cycle is one beat and the beat counter counts 0..BEATS-1.
  - Each beat's parity is checked: expected bit i = ^data[16i+15:16i] ^ PAR_ODD.
  - On the last beat, the FSM returns to IDLE. pay_done pulses and pay_cnt increments the following cycle.
- Protocol errors:
  - hdr_vld in GAPW or PAY sets proto_err; the header is ignored (not counted, not captured) and the packet continues.
  - datareq asserted without hdr_vld while in IDLE also sets proto_err.
- mon_en deasserted mid-packet lets the current packet complete; only new headers are blocked.
- Header in the same cycle as the last beat: the header is flagged as overlap (proto_err) because the FSM is still in PAY. Back-to-back is legal from the cycle after the last beat.
- Counters saturate at all-ones and never wrap.
- Sticky errors: err_clr clears them. If err_clr and a new error occur in the same cycle, the set wins.
- Output timing: hdr_evt and pay_done are registered, so latency is 1 cycle from the triggering input.

Optional Feature:
- Macro SIU_NIU_MON_PAR_CHK_EN.
- Defined: parity checking as above; par_err is a live sticky flag.
- Undefined: the parity XOR tree is not built and par_err is tied to 0; the sio_niu_parity input stays in the port list but is unused.

Decomposition:
- Shared package siu_niu_mon_pkg holds:
  - FSM state enum (IDLE, GAPW, PAY);
  - field position constants RES_TYPE_W=6, TAG_LSB=64, TAG_W=16;
  - PAR_SLICE=16;
  - the parity-function definition.
- One sub-module, siu_niu_mon_ch, implements a single channel: FSM, capture registers, counters and errors.
- The top level instantiates NUM_CH copies in a generate loop and does the slice routing.

Test Plan:
- NUM_CH=1, default parameters; header at cycle 10 with datareq=1, data[127:122]=6'h2A, data[79:64]=16'h1234, followed by 4 beats with correct even parity:
  - hdr_evt at cycle 11; res_type=2A; tag_id=1234;
  - beats at cycles 12-15; pay_done at cycle 16; hdr_cnt=1; pay_cnt=1; no errors.
- Header with datareq=0 → hdr_evt pulses, hdr_has_data=0, no pay_done, pay_cnt stays 0, FSM stays IDLE.
- Beat 2 with parity bit 3 flipped → par_err=1 from the cycle after that beat. err_clr then clears it. With the macro undefined, par_err stays 0.
- hdr_vld during beat 1 → proto_err=1, hdr_cnt unchanged, original tag retained, pay_done still at the expected cycle.
- NUM_CH=2, BEATS=2, GAP=0; simultaneous headers on both channels with different tags → independent captures; both pay_done pulse 3 cycles after the header.
- Reset asserted during beat 2, then a new packet issued → all outputs 0 during reset; the new packet is tracked normally with pay_cnt=1. Separately, 65535 packets with CNT_W=16 → count holds at 16'hFFFF after one more packet.
